roi_downsampler: RTL

ROI_DOWNSAMPLER -- requirements
Module: roi_downsampler

---
 rtl/roi_downsampler_pkg.sv | 37 +++
 rtl/roi_line_acc.sv | 43 ++++
 rtl/roi_downsampler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/roi_downsampler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roi_downsampler_pkg
// Description : ROI geometry defaults, counter/bus widths and the capture
//               FSM state encoding shared by the ROI downsampler files.
// Revision    : 1.0 - initial release
// ============================================================================
package roi_downsampler_pkg;

  // Default ROI geometry (112x112 window reduced by 4x4 blocks to 28x28)
  localparam int C_ROI_ROW0  = 184;
  localparam int C_ROI_COL0  = 320;
  localparam int C_ROI_SIZE  = 112;
  localparam int C_SCALE     = 4;
  localparam int C_OUT_DIM   = C_ROI_SIZE / C_SCALE;
  localparam int C_FRAME_PIX = C_OUT_DIM * C_OUT_DIM;   // 784 output pixels

  // Datapath widths
  localparam int C_ADDR_W = $clog2(C_FRAME_PIX);         // 10 bits, 0..783
  localparam int C_CNT_W  = 10;
  localparam int C_PIX_W  = 8;
  localparam int C_HSUM_W = 10;                          // 4 x 255 = 1020
  localparam int C_SUM_W  = 12;                          // 16 x 255 = 4080

  // Last active column of a video line; the row counter advances after it
  localparam int C_LINE_LAST_COL = 751;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/roi_line_acc.sv
`default_nettype none
// ============================================================================
// Module      : roi_line_acc
// Description : Per-block-column vertical accumulator. A read-modify-write
//               port adds a horizontal 4-pixel sum into entry i_idx; i_clr
//               discards the stored value so the first line of a block row
//               starts a fresh sum. o_sum is the updated value (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module roi_line_acc
  import roi_downsampler_pkg::*;
#(
  parameter int DEPTH = C_OUT_DIM,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic                i_we,
  input  logic                i_clr,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [C_HSUM_W-1:0] i_add,
  output logic [C_SUM_W-1:0]  o_sum
);

  logic [C_SUM_W-1:0] r_mem [DEPTH];
  logic [C_SUM_W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_mem[i_idx];
  assign o_sum  = w_base + C_SUM_W'(i_add);

  // Store the updated column sum; reset clears every entry
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= o_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/roi_downsampler.sv
`default_nettype none
// ============================================================================
// Module      : roi_downsampler
// Description : Tracks raster position of a grayscale video stream, averages
//               SCALE x SCALE blocks inside a fixed ROI and writes one byte per
//               block into a frame buffer on request (cap_req / frame_ack).
// Revision    : 1.0 - initial release
// ============================================================================
module roi_downsampler
  import roi_downsampler_pkg::*;
#(
  parameter int ROI_ROW0 = C_ROI_ROW0,
  parameter int ROI_COL0 = C_ROI_COL0,
  parameter int ROI_SIZE = C_ROI_SIZE,
  parameter int SCALE    = C_SCALE,
  parameter int OUT_DIM  = C_OUT_DIM,
  parameter int INVERT   = 1
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic                vga_vsync,
  input  logic                vga_hsync,
  input  logic                active_video,
  input  logic [C_PIX_W-1:0]  rgb_data_i,
  input  logic                cap_req,
  input  logic                frame_ack,
  output logic                wr_en,
  output logic [C_ADDR_W-1:0] wr_addr,
  output logic [C_PIX_W-1:0]  wr_data,
  output logic                busy,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam int c_scl_log2 = $clog2(SCALE);
  localparam int c_idx_w    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [C_ADDR_W-1:0] c_last_addr = C_ADDR_W'(OUT_DIM * OUT_DIM - 1);
  localparam logic [C_CNT_W-1:0]  c_last_col  = C_CNT_W'(C_LINE_LAST_COL);

  state_t r_state, w_state_nxt;

  logic [C_CNT_W-1:0]    r_col_cnt, r_row_cnt;
  logic                  r_vsync_d;
  logic [C_HSUM_W-1:0]   r_hsum;
  logic                  r_wr_en;
  logic [C_ADDR_W-1:0]   r_wr_addr;
  logic [C_PIX_W-1:0]    r_wr_data;
  logic                  r_frame_err;

  logic [C_CNT_W-1:0]    w_rr, w_cc;
  logic [c_scl_log2-1:0] w_sub_r, w_sub_c;
  logic [c_idx_w-1:0]    w_blk_r, w_blk_c;
  logic                  w_in_roi, w_first_c, w_last_c, w_first_r, w_last_r;
  logic [C_HSUM_W-1:0]   w_hsum;
  logic [C_SUM_W-1:0]    w_blk_sum;
  logic                  w_blk_done, w_wr_fire, w_vs_rise;
  logic [C_PIX_W-1:0]    w_mean, w_pix_out;
  logic [C_ADDR_W-1:0]   w_addr;
  logic                  w_cap_accept, w_abort;

  // Column counter: restarts on hsync, advances per valid pixel
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_col_cnt <= '0;
    end else if (vga_hsync) begin
      r_col_cnt <= '0;
    end else if (active_video) begin
      r_col_cnt <= r_col_cnt + 1'b1;
    end
  end

  // Row counter: restarts on vsync, advances after the last column of a line
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_row_cnt <= '0;
    end else if (vga_vsync) begin
      r_row_cnt <= '0;
    end else if (active_video && (r_col_cnt == c_last_col)) begin
      r_row_cnt <= r_row_cnt + 1'b1;
    end
  end

  // ROI-relative coordinates; positions before the ROI origin wrap to large
  // values, so a single upper-bound compare decides ROI membership.
  assign w_rr     = r_row_cnt - C_CNT_W'(ROI_ROW0);
  assign w_cc     = r_col_cnt - C_CNT_W'(ROI_COL0);
  assign w_in_roi = active_video && (w_rr < C_CNT_W'(ROI_SIZE))
                                 && (w_cc < C_CNT_W'(ROI_SIZE));

  assign w_sub_r   = w_rr[c_scl_log2-1:0];
  assign w_sub_c   = w_cc[c_scl_log2-1:0];
  assign w_blk_r   = c_idx_w'(w_rr >> c_scl_log2);
  assign w_blk_c   = c_idx_w'(w_cc >> c_scl_log2);
  assign w_first_c = ~|w_sub_c;
  assign w_last_c  = &w_sub_c;
  assign w_first_r = ~|w_sub_r;
  assign w_last_r  = &w_sub_r;

  // Running horizontal sum of the current block line, including this pixel
  assign w_hsum = (w_first_c ? '0 : r_hsum) + C_HSUM_W'(rgb_data_i);

  // Hold the partial horizontal sum between pixels of a block line
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_hsum <= '0;
    end else if (w_in_roi) begin
      r_hsum <= w_hsum;
    end
  end

  roi_line_acc #(
    .DEPTH (OUT_DIM),
    .IDX_W (c_idx_w)
  ) u_line_acc (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .i_we    (w_in_roi & w_last_c),
    .i_clr   (w_first_r),
    .i_idx   (w_blk_c),
    .i_add   (w_hsum),
    .o_sum   (w_blk_sum)
  );

  assign w_blk_done = w_in_roi & w_last_c & w_last_r;
  assign w_mean     = C_PIX_W'(w_blk_sum >> (2 * c_scl_log2));
  assign w_pix_out  = (INVERT != 0) ? ~w_mean : w_mean;
  assign w_addr     = C_ADDR_W'(w_blk_r) * C_ADDR_W'(OUT_DIM) + C_ADDR_W'(w_blk_c);

  // A new vsync edge in CAPTURE means the frame ended early. The level that
  // moved ARM into CAPTURE is already seen by r_vsync_d, so it never aborts.
  assign w_vs_rise = vga_vsync & ~r_vsync_d;
  assign w_wr_fire = w_blk_done & (r_state == CAPTURE) & ~w_vs_rise;

  // Delay vsync by one cycle for edge detection
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= vga_vsync;
    end
  end

  // Register the downsampled pixel one cycle after its block closes
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pix_out;
      end
    end
  end

  // FSM state register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; cap_req only counts in IDLE, frame_ack only in DONE
  always_comb begin
    w_state_nxt  = r_state;
    w_cap_accept = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cap_req) begin
          w_state_nxt  = ARM;
          w_cap_accept = 1'b1;
        end
      end
      ARM: begin
        if (vga_vsync) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (r_wr_en && (r_wr_addr == c_last_addr)) begin
          w_state_nxt = DONE;
        end else if (w_vs_rise) begin
          w_state_nxt = ARM;
          w_abort     = 1'b1;
        end
      end
      DONE: begin
        if (frame_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sticky truncation flag, cleared when a new capture is accepted
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_abort) begin
      r_frame_err <= 1'b1;
    end else if (w_cap_accept) begin
      r_frame_err <= 1'b0;
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = (r_state == ARM) || (r_state == CAPTURE);
  assign frame_valid = (r_state == DONE);
  assign frame_err   = r_frame_err;

endmodule
`default_nettype wire
